gene_matcher: RTL and testbench



---
 rtl/gene_matcher.sv | 81 ++++++++
 tb/tb_gene_matcher.sv | 121 ++++++++++++
 2 files changed

// File: rtl/gene_matcher.sv
// Registered 4-base DNA comparator: full-match flag, per-base match vector and mismatch count.
// Optional macro GENE_MATCH_RUN_EN replaces the mismatch count with a saturating full-match run counter.
module gene_matcher (
   input  logic       clk,
   input  logic       rst,
   input  logic       ena,
   input  logic [7:0] ui_in,
   input  logic [7:0] uio_in,
   output logic [7:0] uo_out,
   output logic [7:0] uio_out,
   output logic [7:0] uio_oe
);

   // Number of mismatching bases, i.e. zero bits in the match vector.
   function automatic logic [2:0] zero_count(input logic [3:0] m);
      logic [2:0] cnt;
      cnt = 3'd0;
      for (int i = 0; i < 4; i++) begin
         cnt = cnt + {2'b00, ~m[i]};
      end
      return cnt;
   endfunction

   logic [3:0] match_s;
   logic       full_s;
   logic [2:0] upper_s;
   logic [7:0] uo_out_r;

`ifdef GENE_MATCH_RUN_EN
   logic [2:0] run_r;
`endif

   // Per-base comparison and derived result fields.
   always_comb begin
      match_s = 4'h0;
      for (int i = 0; i < 4; i++) begin
         match_s[i] = (ui_in[2*i +: 2] == uio_in[2*i +: 2]);
      end
      full_s = &match_s;
`ifdef GENE_MATCH_RUN_EN
      if (!full_s) begin
         upper_s = 3'd0;
      end else if (run_r == 3'd7) begin
         upper_s = 3'd7;
      end else begin
         upper_s = run_r + 3'd1;
      end
`else
      upper_s = zero_count(match_s);
`endif
   end

   // Result register: reset has priority, ena=0 holds.
   always_ff @(posedge clk) begin
      if (rst) begin
         uo_out_r <= 8'h00;
      end else if (ena) begin
         uo_out_r <= {upper_s, match_s, full_s};
      end else begin
         uo_out_r <= uo_out_r;
      end
   end

`ifdef GENE_MATCH_RUN_EN
   // Run counter tracks consecutive enabled full matches.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_r <= 3'd0;
      end else if (ena) begin
         run_r <= upper_s;
      end else begin
         run_r <= run_r;
      end
   end
`endif

   assign uo_out  = uo_out_r;
   assign uio_out = 8'h00;
   assign uio_oe  = 8'h00;

endmodule

// File: tb/tb_gene_matcher.sv
// Scoreboard bench for gene_matcher: driver queues hand-computed results, a monitor pops and compares after each edge.
module tb_gene_matcher;

   logic       clk;
   logic       rst;
   logic       ena;
   logic [7:0] ui_in;
   logic [7:0] uio_in;
   logic [7:0] uo_out;
   logic [7:0] uio_out;
   logic [7:0] uio_oe;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   logic [2:0] run_model = 3'd0;
   bit         done = 1'b0;

   gene_matcher dut (
      .clk     (clk),
      .rst     (rst),
      .ena     (ena),
      .ui_in   (ui_in),
      .uio_in  (uio_in),
      .uo_out  (uo_out),
      .uio_out (uio_out),
      .uio_oe  (uio_oe)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one cycle of stimulus; exp is the default-build result word.
   task automatic step(input logic [7:0] g, input logic [7:0] r, input logic e,
                       input logic rs, input logic [7:0] exp);
      logic [7:0] e_word;
      @(negedge clk);
      ui_in  = g;
      uio_in = r;
      ena    = e;
      rst    = rs;
      e_word = exp;
`ifdef GENE_MATCH_RUN_EN
      if (rs) begin
         run_model = 3'd0;
      end else if (e) begin
         if (exp[0]) run_model = (run_model == 3'd7) ? 3'd7 : run_model + 3'd1;
         else        run_model = 3'd0;
      end
      e_word[7:5] = rs ? 3'd0 : run_model;
`endif
      exp_q.push_back(e_word);
   endtask

   // Monitor: compare every output word one step after its sampling edge.
   initial begin
      logic [7:0] want;
      forever begin
         @(posedge clk);
         #1;
         if (exp_q.size() > 0) begin
            want = exp_q.pop_front();
            checks++;
            if (uo_out !== want) begin
               errors++;
               $display("FAIL uo_out: got %h expected %h", uo_out, want);
            end
            checks++;
            if (uio_out !== 8'h00 || uio_oe !== 8'h00) begin
               errors++;
               $display("FAIL uio_tie: got out=%h oe=%h expected 00/00", uio_out, uio_oe);
            end
         end
      end
   end

   initial begin
      rst = 1'b1; ena = 1'b0; ui_in = 8'h00; uio_in = 8'h00;
      step(8'hAA, 8'h55, 1'b1, 1'b1, 8'h00);
      step(8'h3C, 8'hC3, 1'b0, 1'b1, 8'h00);
      step(8'h1B, 8'h1B, 1'b1, 1'b0, 8'h1F);
      step(8'h1B, 8'h5B, 1'b1, 1'b0, 8'h2E);
      step(8'h00, 8'h00, 1'b1, 1'b0, 8'h1F);
      step(8'hFF, 8'hFF, 1'b1, 1'b0, 8'h1F);
      step(8'hAA, 8'hFF, 1'b1, 1'b0, 8'h80);
      step(8'h1B, 8'h1A, 1'b1, 1'b0, 8'h3C);
      step(8'h1B, 8'h1B, 1'b1, 1'b0, 8'h1F);
      step(8'hAA, 8'hFF, 1'b0, 1'b0, 8'h1F);
      step(8'h1B, 8'h5B, 1'b0, 1'b0, 8'h1F);
      step(8'hAA, 8'hFF, 1'b0, 1'b1, 8'h00);
      step(8'hAA, 8'hFF, 1'b0, 1'b0, 8'h00);
      step(8'hAA, 8'hFF, 1'b1, 1'b0, 8'h80);
      step(8'h1B, 8'h1B, 1'b1, 1'b1, 8'h00);
      // Nine consecutive matches, then a total mismatch.
      for (int k = 0; k < 9; k++) begin
         step(8'hE4, 8'hE4, 1'b1, 1'b0, 8'h1F);
      end
      step(8'hAA, 8'hFF, 1'b1, 1'b0, 8'h80);
      step(8'h6C, 8'h6C, 1'b1, 1'b0, 8'h1F);
      step(8'h6C, 8'h6C, 1'b0, 1'b0, 8'h1F);
      step(8'h6C, 8'h6C, 1'b1, 1'b0, 8'h1F);
      // Drain the scoreboard within a bounded number of cycles.
      for (int w = 0; w < 5 && exp_q.size() > 0; w++) @(posedge clk);
      #2;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: got %0d pending expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   // Global time bound.
   initial begin
      #100000;
      $display("FAIL timeout: got no completion expected finish");
      $fatal(1, "timeout");
   end

endmodule
